// File: rtl/debug_pkg.sv
// Shared command/reply bytes, controller state encoding and serializer request type
// for the UART debug unit.
package debug_pkg;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_CLEAR = 8'h43;
    localparam logic [7:0] CMD_PC    = 8'h50;
    localparam logic [7:0] CMD_DUMP  = 8'h44;
    localparam logic [7:0] REPLY_ACK = 8'h4B;
    localparam logic [7:0] REPLY_ERR = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE, ST_RUN, ST_STEP, ST_LOAD, ST_SEND, ST_WAIT_TX, ST_ACK
    } dbg_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        single;
    } ser_req_t;

    // Single-byte replies ride in the MSB so the serializer always shifts from the top.
    function automatic ser_req_t byte_req(input logic [7:0] b);
        return '{data: {b, 24'h0}, single: 1'b1};
    endfunction
endpackage

// File: rtl/word_tx_serializer.sv
// Sends a 32-bit word (or only its top byte) MSB first over a tx_start/tx_done
// byte handshake; done is a combinational pulse on the final tx_done.
module word_tx_serializer
    import debug_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  ser_req_t   req,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] w_data,
    output logic       done
);
    dbg_state_t  st;
    logic [23:0] rest;
    logic [1:0]  left;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= ST_IDLE;
            tx_start <= 1'b0;
            w_data   <= 8'h00;
            rest     <= 24'h0;
            left     <= 2'd0;
        end else begin
            tx_start <= 1'b0;
            case (st)
                ST_IDLE: if (load) begin
                    w_data   <= req.data[31:24];
                    rest     <= req.data[23:0];
                    left     <= req.single ? 2'd0 : 2'd3;
                    tx_start <= 1'b1;
                    st       <= ST_SEND;
                end
                ST_SEND: st <= ST_WAIT_TX;
                // w_data holds until tx_done; tx_done in any other state is ignored.
                ST_WAIT_TX: if (tx_done) begin
                    if (left != 2'd0) begin
                        w_data   <= rest[23:16];
                        rest     <= {rest[15:0], 8'h00};
                        left     <= left - 2'd1;
                        tx_start <= 1'b1;
                        st       <= ST_SEND;
                    end else begin
                        st <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign done = (st == ST_WAIT_TX) && tx_done && (left == 2'd0);
endmodule

// File: rtl/debug_unit.sv
// UART-driven processor debug controller: run/step/reset the core, read the PC
// and dump the debug word bus, replying through one word serializer.
module debug_unit
    import debug_pkg::*;
#(
    parameter int DUMP_WORDS = 40,
    parameter int ADDR_BITS  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_done,
    input  logic [7:0]           r_data,
    input  logic                 tx_done,
    output logic                 tx_start,
    output logic [7:0]           w_data,
    input  logic [31:0]          pc,
    output logic [ADDR_BITS-1:0] dbg_addr,
    input  logic [31:0]          dbg_data,
    input  logic                 halted,
    output logic                 cpu_enable,
    output logic                 cpu_reset,
    output logic                 busy
);
    localparam logic [ADDR_BITS-1:0] LAST_WORD = ADDR_BITS'(DUMP_WORDS - 1);

    dbg_state_t state;
    logic       dumping;
    logic       ser_load;
    logic       ser_done;
    ser_req_t   ser_req;

    // Loads are issued in the same cycle the decision is made so the first
    // tx_start lands one cycle after rx_done for 'P' and error replies.
    always_comb begin
        ser_load = 1'b0;
        ser_req  = '{data: 32'h0, single: 1'b0};
        case (state)
            ST_IDLE: if (rx_done) begin
                case (r_data)
                    CMD_RUN, CMD_STEP, CMD_CLEAR, CMD_DUMP: ser_load = 1'b0;
                    CMD_PC: begin
                        ser_load = 1'b1;
                        ser_req  = '{data: pc, single: 1'b0};
                    end
                    default: begin
                        ser_load = 1'b1;
                        ser_req  = byte_req(REPLY_ERR);
                    end
                endcase
            end
            ST_LOAD: begin
                ser_load = 1'b1;
                ser_req  = '{data: dbg_data, single: 1'b0};
            end
            ST_ACK: begin
                ser_load = 1'b1;
                ser_req  = byte_req(REPLY_ACK);
            end
            default: ser_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            dbg_addr   <= '0;
            cpu_enable <= 1'b0;
            cpu_reset  <= 1'b0;
            dumping    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (rx_done) begin
                    case (r_data)
                        CMD_RUN:   begin cpu_enable <= 1'b1; state <= ST_RUN;  end
                        CMD_STEP:  begin cpu_enable <= 1'b1; state <= ST_STEP; end
                        CMD_CLEAR: begin cpu_reset  <= 1'b1; state <= ST_STEP; end
                        CMD_DUMP: begin
                            dbg_addr <= '0;
                            dumping  <= 1'b1;
                            state    <= ST_LOAD;
                        end
                        default:   state <= ST_SEND;
                    endcase
                end
                ST_RUN: if (halted) begin
                    cpu_enable <= 1'b0;
                    state      <= ST_ACK;
                end
                ST_STEP: begin
                    cpu_enable <= 1'b0;
                    cpu_reset  <= 1'b0;
                    state      <= ST_ACK;
                end
                ST_LOAD, ST_ACK: state <= ST_SEND;
                ST_SEND: if (ser_done) begin
                    if (dumping && dbg_addr != LAST_WORD) begin
                        dbg_addr <= dbg_addr + 1'b1;
                        state    <= ST_LOAD;
                    end else begin
                        dbg_addr <= '0;
                        dumping  <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    word_tx_serializer u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .req      (ser_req),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .w_data   (w_data),
        .done     (ser_done)
    );
endmodule

// File: tb/tb_debug_unit.sv
// Randomized scoreboard bench for debug_unit: stimulus pushes the bytes each
// command must produce, a monitor pops and checks them as tx_start appears.
module tb_debug_unit;
    localparam int DW = 4;
    localparam int AB = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_done = 1'b0;
    logic [7:0]    r_data = 8'h00;
    logic          tx_done = 1'b0;
    logic          tx_start;
    logic [7:0]    w_data;
    logic [31:0]   pc = 32'h0;
    logic [AB-1:0] dbg_addr;
    logic [31:0]   dbg_data;
    logic          halted = 1'b0;
    logic          cpu_enable;
    logic          cpu_reset;
    logic          busy;

    debug_unit #(.DUMP_WORDS(DW), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .r_data(r_data),
        .tx_done(tx_done), .tx_start(tx_start), .w_data(w_data), .pc(pc),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .halted(halted),
        .cpu_enable(cpu_enable), .cpu_reset(cpu_reset), .busy(busy)
    );

    always #5 clk = ~clk;
    assign dbg_data = 32'h100 + 32'(dbg_addr);

    typedef struct {
        logic [7:0]    b;
        logic [AB-1:0] a;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         en_cnt = 0;
    int         rs_cnt = 0;
    int         ts_cnt = 0;
    logic       in_flight = 1'b0;
    logic       chk_busy = 1'b0;
    logic [7:0] held = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // UART transmitter model: random byte time, plus stray tx_done pulses while idle.
    initial begin
        forever begin
            @(posedge clk); #1;
            tx_done = 1'b0;
            if (tx_start) begin
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1 tx_done = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
                tx_done = 1'b1;
            end
        end
    end

    // Monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (!rst) begin
            in_flight = 1'b0;
            chk_busy  = 1'b0;
        end else begin
            if (chk_busy) begin
                chk("busy_drop", 32'(busy), 32'd0);
                chk_busy = 1'b0;
            end
            if (cpu_enable) en_cnt++;
            if (cpu_reset) rs_cnt++;
            if (tx_start) chk("one_in_flight", 32'(in_flight), 32'd0);
            if (tx_done && in_flight) begin
                chk("w_data_stable", 32'(w_data), 32'(held));
                in_flight = 1'b0;
                if (exp_q.size() == 0) chk_busy = 1'b1;
            end
            if (tx_start) begin
                ts_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got byte %h, expected none at %0t", w_data, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("tx_byte", 32'(w_data), 32'(e.b));
                    chk("tx_addr", 32'(dbg_addr), 32'(e.a));
                end
                held      = w_data;
                in_flight = 1'b1;
            end
        end
    end

    task automatic send_cmd(input logic [7:0] b);
        @(posedge clk); #1;
        rx_done = 1'b1;
        r_data  = b;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    // Waits for busy to fall, throwing random commands at the busy unit meanwhile.
    task automatic wait_idle();
        logic [7:0] cmds [5];
        int n;
        cmds = '{8'h52, 8'h53, 8'h43, 8'h50, 8'h44};
        n = 0;
        forever begin
            @(posedge clk); #1;
            rx_done = 1'b0;
            if (!busy) break;
            if (++n > 3000) begin
                chk("idle_timeout", 32'(busy), 32'd0);
                break;
            end
            if ($urandom_range(0, 3) == 0) begin
                rx_done = 1'b1;
                r_data  = cmds[$urandom_range(0, 4)];
            end
        end
        rx_done = 1'b0;
    endtask

    // d: halted rises d cycles after the command (0 = already halted).
    task automatic run_cmd(input logic [7:0] b, input int d, input logic [31:0] pcv);
        int en0, rs0, exp_en, exp_rs;
        en0 = en_cnt; rs0 = rs_cnt; exp_en = 0; exp_rs = 0;
        halted = (b == 8'h52 && d == 0);
        case (b)
            8'h50: begin
                pc = pcv;
                for (int i = 3; i >= 0; i--) exp_q.push_back('{8'(pcv >> (8 * i)), '0});
            end
            8'h44: for (int w = 0; w < DW; w++) begin
                logic [31:0] v;
                v = 32'h100 + 32'(w);
                for (int i = 3; i >= 0; i--) exp_q.push_back('{8'(v >> (8 * i)), AB'(w)});
            end
            8'h52: begin exp_en = (d == 0) ? 1 : d; exp_q.push_back('{8'h4B, '0}); end
            8'h53: begin exp_en = 1; exp_q.push_back('{8'h4B, '0}); end
            8'h43: begin exp_rs = 1; exp_q.push_back('{8'h4B, '0}); end
            default: exp_q.push_back('{8'h3F, '0});
        endcase
        send_cmd(b);
        case (b)
            8'h50: chk("pc_first_tx", 32'(tx_start), 32'd1);
            8'h53: chk("step_enable", 32'(cpu_enable), 32'd1);
            8'h43: chk("clear_reset", 32'(cpu_reset), 32'd1);
            8'h44: chk("dump_addr0", 32'(dbg_addr), 32'd0);
            default: chk("busy_set", 32'(busy), 32'd1);
        endcase
        if (b == 8'h50) begin
            @(posedge clk); #1;
            pc = $urandom;
        end
        if (b == 8'h52 && d > 0) begin
            repeat (d - 1) @(posedge clk);
            #1 halted = 1'b1;
        end
        wait_idle();
        halted = 1'b0;
        chk("enable_cycles", 32'(en_cnt - en0), 32'(exp_en));
        chk("reset_cycles", 32'(rs_cnt - rs0), 32'(exp_rs));
        chk("bytes_pending", 32'(exp_q.size()), 32'd0);
        chk("addr_idle", 32'(dbg_addr), 32'd0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    task automatic reset_mid_dump();
        int base, n;
        base = ts_cnt;
        n = 0;
        for (int w = 0; w < DW; w++)
            for (int i = 3; i >= 0; i--)
                exp_q.push_back('{8'((32'h100 + 32'(w)) >> (8 * i)), AB'(w)});
        send_cmd(8'h44);
        while (ts_cnt < base + 2 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("dump_two_bytes", 32'(ts_cnt - base), 32'd2);
        #2 rst = 1'b0;
        #1;
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_w_data", 32'(w_data), 32'd0);
        chk("rst_dbg_addr", 32'(dbg_addr), 32'd0);
        chk("rst_busy", {30'd0, busy, cpu_enable | cpu_reset}, 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        base = ts_cnt;
        repeat (50) @(posedge clk);
        #1;
        chk("no_tx_after_rst", 32'(ts_cnt - base), 32'd0);
        chk("idle_after_rst", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("reset_outputs", {20'd0, tx_start, w_data, cpu_enable, cpu_reset, busy}, 32'd0);
        chk("reset_addr", 32'(dbg_addr), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        run_cmd(8'h50, 0, 32'hDEADBEEF);
        run_cmd(8'h44, 0, 32'h0);
        run_cmd(8'h52, 50, 32'h0);
        run_cmd(8'h52, 0, 32'h0);
        run_cmd(8'h52, 1, 32'h0);
        run_cmd(8'h53, 0, 32'h0);
        run_cmd(8'h43, 0, 32'h0);
        run_cmd(8'h7A, 0, 32'h0);
        reset_mid_dump();
        run_cmd(8'h50, 0, $urandom);

        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 5))
                0: run_cmd(8'h50, 0, $urandom);
                1: run_cmd(8'h44, 0, 32'h0);
                2: run_cmd(8'h52, $urandom_range(0, 20), 32'h0);
                3: run_cmd(8'h53, 0, 32'h0);
                4: run_cmd(8'h43, 0, 32'h0);
                default: begin
                    do b = 8'($urandom);
                    while (b == 8'h52 || b == 8'h53 || b == 8'h43 || b == 8'h50 || b == 8'h44);
                    run_cmd(b, 0, 32'h0);
                end
            endcase
        end

        repeat (10) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
